difftest_commit_queue: RTL and testbench

//  Writeback-side retire buffer feeding the DPI difftest sink. Accepts retire events from WB, buffers

---
 rtl/difftest_commit_queue.sv | 150 +++++++++++++++
 tb/tb_difftest_commit_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/difftest_commit_queue.sv
// Retire buffer between WB and difftest: FIFO of retire events drained into a shadow register file.
// Optional halt-on-ebreak reporting is built when DIFF_TRAP_EN is defined.
module difftest_commit_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 64
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst,
    input  logic                     in_wen,
    input  logic [4:0]               in_rd,
    input  logic [31:0]              in_wdata,
    input  logic                     drain_en,
    output logic                     wb_commit,
    output logic [31:0]              commit_pc,
    output logic [1023:0]            s_regs_flat,
    output logic [CNT_W-1:0]         instret,
    output logic [$clog2(DEPTH):0]   q_count
`ifdef DIFF_TRAP_EN
    ,
    output logic                     halt,
    output logic [31:0]              halt_code
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]      PTR_ONE = (PW+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [PW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]      pc_mem    [DEPTH];
    logic             wen_mem   [DEPTH];
    logic [4:0]       rd_mem    [DEPTH];
    logic [31:0]      wdata_mem [DEPTH];
    logic [31:0]      regs_q    [1:31];
    logic [31:0]      regs_d    [1:31];
    logic             wb_commit_q, wb_commit_d;
    logic [31:0]      commit_pc_q, commit_pc_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic          full, empty, stop, enq, deq;
    logic [PW-1:0] head_idx, tail_idx;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign head_idx = rd_ptr_q[PW-1:0];
    assign tail_idx = wr_ptr_q[PW-1:0];
    assign in_ready = !full && !stop;
    assign enq      = in_valid && in_ready;
    assign deq      = !empty && drain_en && !stop;

`ifdef DIFF_TRAP_EN
    logic [31:0] inst_mem [DEPTH];
    logic        pend_q, pend_d, halt_q, halt_d;
    logic [31:0] halt_code_q, halt_code_d;

    // Queue freezes as soon as ebreak retires; halt reports one cycle after its commit pulse.
    assign stop = pend_q || halt_q;

    always_comb begin
        pend_d      = pend_q || (deq && (inst_mem[head_idx] == 32'h0010_0073));
        halt_d      = halt_q || pend_q;
        halt_code_d = halt_code_q;
        if (pend_q && !halt_q) halt_code_d = regs_q[10];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q      <= 1'b0;
            halt_q      <= 1'b0;
            halt_code_q <= '0;
        end else begin
            pend_q      <= pend_d;
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) inst_mem[tail_idx] <= in_inst;
    end

    assign halt      = halt_q;
    assign halt_code = halt_code_q;
`else
    logic unused_inst;
    assign stop        = 1'b0;
    assign unused_inst = ^in_inst;
`endif

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wb_commit_d = deq;
        commit_pc_d = commit_pc_q;
        instret_d   = instret_q;
        regs_d      = regs_q;
        if (enq) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (deq) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            commit_pc_d = pc_mem[head_idx];
            instret_d   = instret_q + CNT_ONE;
            if (wen_mem[head_idx] && (rd_mem[head_idx] != 5'd0))
                regs_d[rd_mem[head_idx]] = wdata_mem[head_idx];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wb_commit_q <= 1'b0;
            commit_pc_q <= '0;
            instret_q   <= '0;
            for (int i = 1; i < 32; i++) regs_q[i] <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wb_commit_q <= wb_commit_d;
            commit_pc_q <= commit_pc_d;
            instret_q   <= instret_d;
            for (int i = 1; i < 32; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Payload storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clock) begin
        if (enq) begin
            pc_mem[tail_idx]    <= in_pc;
            wen_mem[tail_idx]   <= in_wen;
            rd_mem[tail_idx]    <= in_rd;
            wdata_mem[tail_idx] <= in_wdata;
        end
    end

    always_comb begin
        s_regs_flat = '0;
        for (int i = 1; i < 32; i++) s_regs_flat[32*i +: 32] = regs_q[i];
    end

    assign wb_commit = wb_commit_q;
    assign commit_pc = commit_pc_q;
    assign instret   = instret_q;
    assign q_count   = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Directed bench for difftest_commit_queue with hand-computed expectations.
module tb_difftest_commit_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 64;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid, in_ready, in_wen, drain_en, wb_commit;
    logic [31:0]   in_pc, in_inst, in_wdata, commit_pc;
    logic [4:0]    in_rd;
    logic [1023:0] s_regs_flat;
    logic [CNT_W-1:0] instret;
    logic [2:0]    q_count;
`ifdef DIFF_TRAP_EN
    logic          halt;
    logic [31:0]   halt_code;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    difftest_commit_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .in_wen      (in_wen),
        .in_rd       (in_rd),
        .in_wdata    (in_wdata),
        .drain_en    (drain_en),
        .wb_commit   (wb_commit),
        .commit_pc   (commit_pc),
        .s_regs_flat (s_regs_flat),
        .instret     (instret),
        .q_count     (q_count)
`ifdef DIFF_TRAP_EN
        ,
        .halt        (halt),
        .halt_code   (halt_code)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] xreg(input int i);
        return s_regs_flat[32*i +: 32];
    endfunction

    task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic wen,
                        input logic [4:0] rd, input logic [31:0] wdata);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        in_wen   = wen;
        in_rd    = rd;
        in_wdata = wdata;
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_pc    = '0;
        in_inst  = '0;
        in_wen   = 1'b0;
        in_rd    = '0;
        in_wdata = '0;
        drain_en = 1'b0;
        #2;
        check("rst_q_count",   q_count,     0);
        check("rst_wb_commit", wb_commit,   0);
        check("rst_commit_pc", commit_pc,   0);
        check("rst_regs",      s_regs_flat, 0);
        check("rst_instret",   instret,     0);
        #10 reset_n = 1'b1;
        #1 check("rst_in_ready", in_ready, 1);

        // Single retire: enqueue, then commit two edges later.
        drain_en = 1'b1;
        push(32'h8000_0000, 32'h0000_0013, 1'b1, 5'd5, 32'h1234);
        tick();
        in_valid = 1'b0;
        check("t2_no_early_commit", wb_commit, 0);
        check("t2_q_count1",        q_count,   1);
        tick();
        check("t2_wb_commit", wb_commit, 1);
        check("t2_commit_pc", commit_pc, 32'h8000_0000);
        check("t2_x5",        xreg(5),   32'h1234);
        check("t2_instret",   instret,   1);
        check("t2_q_count0",  q_count,   0);
        tick();
        check("t2_pulse_end", wb_commit, 0);
        check("t2_pc_hold",   commit_pc, 32'h8000_0000);

        // Write to x0 is dropped but still commits.
        push(32'h8000_0004, 32'h0000_0013, 1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        in_valid = 1'b0;
        tick();
        check("t4_wb_commit", wb_commit, 1);
        check("t4_commit_pc", commit_pc, 32'h8000_0004);
        check("t4_x0",        xreg(0),   0);
        check("t4_x5_kept",   xreg(5),   32'h1234);
        check("t4_instret",   instret,   2);

        // Fill to DEPTH with drain blocked; fifth push refused.
        drain_en = 1'b0;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            push(32'h100 + 32'(4*i), 32'h13, 1'b1, 5'(i+1), 32'hA0 + 32'(i));
            tick();
        end
        check("t3_full_ready", in_ready, 0);
        check("t3_full_count", q_count,  4);
        push(32'h200, 32'h13, 1'b1, 5'd9, 32'hDEAD);
        tick();
        in_valid = 1'b0;
        check("t3_push5_ignored", q_count, 4);
        drain_en = 1'b1;
        tick();
        check("t3_first_commit", wb_commit, 1);
        check("t3_first_pc",     commit_pc, 32'h100);
        check("t3_ready_again",  in_ready,  1);
        check("t3_count3",       q_count,   3);
        for (int i = 1; i < DEPTH; i++) begin
            tick();
            check($sformatf("t3_commit%0d", i), wb_commit, 1);
            check($sformatf("t3_pc%0d", i),     commit_pc, 32'h100 + 32'(4*i));
        end
        tick();
        check("t3_no_fifth", wb_commit, 0);
        check("t3_empty",    q_count,   0);
        check("t3_instret",  instret,   6);
        for (int i = 1; i <= DEPTH; i++)
            check($sformatf("t3_x%0d", i), xreg(i), 32'hA0 + 32'(i-1));
        check("t3_x9_untouched", xreg(9), 0);

        // Streaming enq+deq with one entry resident; pointers wrap several times.
        drain_en = 1'b0;
        push(32'h300, 32'h13, 1'b1, 5'd6, 32'd0);
        tick();
        drain_en = 1'b1;
        for (int k = 1; k <= 3*DEPTH; k++) begin
            push(32'h300 + 32'(4*k), 32'h13, 1'b1, 5'd6, 32'(k));
            tick();
            check($sformatf("t5_commit%0d", k), wb_commit, 1);
            check($sformatf("t5_pc%0d", k),     commit_pc, 32'h300 + 32'(4*(k-1)));
            check($sformatf("t5_count%0d", k),  q_count,   1);
        end
        in_valid = 1'b0;
        tick();
        check("t5_last_pc", commit_pc, 32'h330);
        check("t5_empty",   q_count,   0);
        check("t5_x6",      xreg(6),   32'd12);
        check("t5_instret", instret,   19);

        // Asynchronous reset with three entries queued.
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(32'h700 + 32'(4*i), 32'h13, 1'b1, 5'd7, 32'h77);
            tick();
        end
        in_valid = 1'b0;
        check("t1_count3", q_count, 3);
        #2 reset_n = 1'b0;
        #1;
        check("t1_q_count",  q_count,     0);
        check("t1_wb_commit", wb_commit,  0);
        check("t1_regs",     s_regs_flat, 0);
        check("t1_instret",  instret,     0);
        check("t1_commit_pc", commit_pc,  0);
        #1 reset_n = 1'b1;
        drain_en = 1'b1;
        tick();
        push(32'h400, 32'h13, 1'b0, 5'd1, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();
        check("t1_post_pc",      commit_pc, 32'h400);
        check("t1_post_instret", instret,   1);
        tick();
        check("t1_nothing_stale", wb_commit, 0);

`ifdef DIFF_TRAP_EN
        check("t6_halt_rst", halt, 0);
        push(32'h500 - 32'h4, 32'h13, 1'b1, 5'd10, 32'h2A);
        tick();
        push(32'h500, 32'h0010_0073, 1'b0, 5'd0, 32'h0);
        tick();
        push(32'h504, 32'h13, 1'b1, 5'd11, 32'h55);
        tick();
        check("t6_ebreak_commit", wb_commit, 1);
        check("t6_ebreak_pc",     commit_pc, 32'h500);
        check("t6_halt_not_yet",  halt,      0);
        check("t6_ready_blocked", in_ready,  0);
        push(32'h508, 32'h13, 1'b1, 5'd12, 32'h66);
        tick();
        check("t6_halt",         halt,      1);
        check("t6_halt_code",    halt_code, 32'h2A);
        check("t6_no_more_deq",  wb_commit, 0);
        check("t6_push_refused", q_count,   1);
        tick();
        in_valid = 1'b0;
        check("t6_halt_sticky", halt,      1);
        check("t6_x11_clean",   xreg(11),  0);
        check("t6_instret",     instret,   3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
